// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Conditions the raw board inputs that feed multi_decade_counter. The two
//   pushbuttons are synchronized, debounced and edge-detected. A RUN press
//   toggles the run enable. A LOAD press captures the synchronized switches
//   and raises load_enable. load_enable stays high until the slow divided
//   clock cdone has completed a rising edge, so the cdone-clocked counter
//   cannot miss the request.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   btn_run_raw   raw RUN pushbutton (asynchronous, active-high)
//   btn_load_raw  raw LOAD pushbutton (asynchronous, active-high)
//   sw_load_raw   raw 4-bit load-value switches (asynchronous)
//   cdone         divided clock, already registered in the clk domain
//   enable        run enable to the counter
//   load          captured load value to the counter
//   load_enable   load request to the counter
//   load_busy     high while a load request is outstanding
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,  // must be >= 2
  parameter int CNT_W           = 20        // 2**CNT_W > DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run_raw,
  input  logic       btn_load_raw,
  input  logic [3:0] sw_load_raw,
  input  logic       cdone,
  output logic       enable,
  output logic [3:0] load,
  output logic       load_enable,
  output logic       load_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLD
  } state_t;

  // Button index 0 is RUN, index 1 is LOAD.
  localparam int NBTN = 2;
  localparam int BTN_RUN  = 0;
  localparam int BTN_LOAD = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  btn_meta;
  logic [NBTN-1:0]  btn_sync;
  logic [NBTN-1:0]  stable;
  logic [NBTN-1:0]  stable_q;
  logic [NBTN-1:0]  press;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [3:0]       sw_meta;
  logic [3:0]       sw_sync;
  logic             cdone_q;
  logic             rise;
  logic             capture;
  state_t           state;
  state_t           state_next;

  assign btn_raw = {btn_load_raw, btn_run_raw};

  // Two-flop synchronizers for the buttons and the switches. The switches
  // are not debounced; they are only sampled at the moment of a LOAD press.
  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= sw_load_raw;
      sw_sync  <= sw_meta;
    end
  end

  // Debouncer: a synchronized level must differ from the accepted value for
  // DEBOUNCE_CYCLES consecutive cycles; any return to equality restarts it.
  // NOTE: the counter array is reset explicitly; it is a set of flops, not a
  // RAM, and a stale count after reset would shorten the first debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < NBTN; i++) begin
        if (btn_sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= btn_sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // One-cycle pulse on each debounced press; releases produce nothing.
  assign press = stable & ~stable_q;

  always_ff @(posedge clk) begin
    if (reset) cdone_q <= 1'b0;
    else       cdone_q <= cdone;
  end

  assign rise = cdone & ~cdone_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Load handshake. A rise only counts in ARMED, so load_enable has been high
  // for at least one clk before the cdone edge the counter samples on. HOLD
  // exits on the registered cdone level, watching the fall through the same
  // flop that detected the rise.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[BTN_LOAD]) begin
          capture    = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (rise) state_next = HOLD;
      end
      HOLD: begin
        if (!cdone_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs. Presses arriving in ARMED or HOLD do not capture, so
  // load keeps the value the counter is being asked to load.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      load        <= '0;
      load_enable <= 1'b0;
      load_busy   <= 1'b0;
    end else begin
      if (press[BTN_RUN]) enable <= ~enable;
      if (capture)        load   <= sw_sync;
      load_enable <= (state_next != IDLE);
      load_busy   <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//   Directed self-checking bench for input_conditioner with
//   DEBOUNCE_CYCLES=4. Inputs change 1 time unit after a rising edge, and
//   outputs are sampled at that same point, so "edge N" below is the N-th
//   rising clk edge after an input change.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run_raw;
  logic       btn_load_raw;
  logic [3:0] sw_load_raw;
  logic       cdone;
  logic       enable;
  logic [3:0] load;
  logic       load_enable;
  logic       load_busy;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_raw (btn_run_raw),
    .btn_load_raw(btn_load_raw),
    .sw_load_raw (sw_load_raw),
    .cdone       (cdone),
    .enable      (enable),
    .load        (load),
    .load_enable (load_enable),
    .load_busy   (load_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic en,
                            input logic [3:0] ld, input logic le,
                            input logic bz);
    check({tag, ".enable"},      32'(enable),      32'(en));
    check({tag, ".load"},        32'(load),        32'(ld));
    check({tag, ".load_enable"}, 32'(load_enable), 32'(le));
    check({tag, ".load_busy"},   32'(load_busy),   32'(bz));
  endtask

  logic seen_le;

  initial begin
    // ---- Reset with every raw input high ----
    reset        = 1'b1;
    btn_run_raw  = 1'b1;
    btn_load_raw = 1'b1;
    sw_load_raw  = 4'hF;
    cdone        = 1'b0;
    step(1);
    check_outs("rst_first", 1'b0, 4'h0, 1'b0, 1'b0);
    step(2);
    check_outs("rst_last", 1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    check_outs("post_rst_e1", 1'b0, 4'h0, 1'b0, 1'b0);
    step(DEB + 1);                       // edge 6
    check("post_rst_e6.enable", 32'(enable), 32'd0);
    step(1);                             // edge 7: both presses register
    check_outs("post_rst_e7", 1'b1, 4'hF, 1'b1, 1'b1);

    // Complete that load handshake, then release both buttons.
    cdone = 1'b1;
    step(2);
    cdone = 1'b0;
    step(3);
    check("drain.load_enable", 32'(load_enable), 32'd0);
    btn_run_raw  = 1'b0;
    btn_load_raw = 1'b0;
    step(10);
    check("release_no_toggle.enable", 32'(enable), 32'd1);

    // Clean reset with inputs low for the following tests.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    check_outs("clean_rst", 1'b0, 4'h0, 1'b0, 1'b0);

    // ---- Bounce: toggle every 2 clk for 12 cycles, then hold high ----
    for (int i = 0; i < 3; i++) begin
      btn_run_raw = 1'b1;
      step(2);
      btn_run_raw = 1'b0;
      step(2);
    end
    check("bounce.enable", 32'(enable), 32'd0);
    btn_run_raw = 1'b1;                  // last raw edge
    step(DEB + 2);                       // edge 6
    check("bounce_e6.enable", 32'(enable), 32'd0);
    step(1);                             // edge 7
    check("bounce_e7.enable", 32'(enable), 32'd1);
    step(50);
    check("bounce_hold.enable", 32'(enable), 32'd1);
    btn_run_raw = 1'b0;
    step(10);
    btn_run_raw = 1'b1;
    step(10);
    check("second_press.enable", 32'(enable), 32'd0);
    btn_run_raw = 1'b0;
    step(10);

    // ---- Glitch: 3-cycle LOAD pulse is rejected ----
    btn_load_raw = 1'b1;
    step(3);
    btn_load_raw = 1'b0;
    seen_le = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      seen_le = seen_le | load_enable;
    end
    check("glitch.load_enable_seen", 32'(seen_le), 32'd0);
    check("glitch.load", 32'(load), 32'd0);

    // ---- Handshake ----
    sw_load_raw = 4'h9;
    cdone       = 1'b0;
    step(3);
    btn_load_raw = 1'b1;
    step(DEB + 2);                       // edge 6
    check("hs_e6.load_enable", 32'(load_enable), 32'd0);
    step(1);                             // edge 7
    check_outs("hs_e7", 1'b0, 4'h9, 1'b1, 1'b1);
    step(20);
    check_outs("hs_hold20", 1'b0, 4'h9, 1'b1, 1'b1);

    // ---- Dropped press while ARMED ----
    btn_load_raw = 1'b0;
    step(10);
    sw_load_raw  = 4'h5;
    btn_load_raw = 1'b1;
    step(10);
    check_outs("drop_armed", 1'b0, 4'h9, 1'b1, 1'b1);
    btn_load_raw = 1'b0;
    step(10);

    cdone = 1'b1;
    step(5);
    check_outs("hs_cdone_hi", 1'b0, 4'h9, 1'b1, 1'b1);
    cdone = 1'b0;
    step(1);
    check("hs_fall_e1.load_enable", 32'(load_enable), 32'd1);
    step(1);
    check_outs("hs_fall_e2", 1'b0, 4'h9, 1'b0, 1'b0);

    // ---- Later press in IDLE captures 5; RUN pressed alongside ----
    btn_run_raw  = 1'b1;
    btn_load_raw = 1'b1;
    step(DEB + 3);
    check_outs("idle_press", 1'b1, 4'h5, 1'b1, 1'b1);
    cdone = 1'b1;
    step(2);                             // now in HOLD
    check("in_hold.load_busy", 32'(load_busy), 32'd1);

    // ---- Reset mid-operation ----
    reset = 1'b1;
    step(1);
    check_outs("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    cdone = 1'b0;
    step(1);
    check_outs("mid_rst_rel_e1", 1'b0, 4'h0, 1'b0, 1'b0);
    step(DEB + 1);                       // edge 6
    check("held_e6.load_enable", 32'(load_enable), 32'd0);
    step(1);                             // edge 7: held buttons re-press
    check_outs("held_e7", 1'b1, 4'h5, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw board inputs that drive multi_decade_counter.
- Per-button stages: two-flop synchronizer, counter-based debouncer, press-edge detector.
- Toggles the counter's run enable on each debounced RUN press.
- On a LOAD press, captures the 4-bit load switches and holds load_enable high until the slow divided clock (cdone) has completed a rising edge. The counter clocked by cdone therefore cannot miss the request.
- Sits between the board pins and multi_decade_counter, in the clk domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles a synchronized button must differ from its stable value before the change is accepted (10 ms at 100 MHz). Minimum legal value is 2.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_run_raw  input  1  raw RUN pushbutton, asynchronous, active-high
- btn_load_raw  input  1  raw LOAD pushbutton, asynchronous, active-high
- sw_load_raw  input  4  raw load-value switches, asynchronous
- cdone  input  1  divided clock from clock_divider, registered in the clk domain (no synchronizer)
- enable  output  1  run enable to the counter
- load  output  4  captured load value to the counter
- load_enable  output  1  load request to the counter, held per the handshake below
- load_busy  output  1  high while a load request is outstanding

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sampled on a clk rising edge):
  - Outputs: enable=0, load=0, load_enable=0, load_busy=0.
  - Internal: all synchronizer flops=0, stable button values=0, debounce counters=0, cdone_q=0, FSM=IDLE.
  - Reset wins over every simultaneous event.
- Synchronization: btn_run_raw, btn_load_raw and each bit of sw_load_raw pass through 2 flops. Switches are not debounced; they are sampled from the synchronized value.
- Debounce, per button, independent instances:
  - If sync == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then stable <= sync and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any return to equality before terminal count clears cnt, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press detect: press = stable & ~stable_q. It is a one-cycle pulse, and releases generate nothing.
- Latency: a raw edge held steady is acted on at the (DEBOUNCE_CYCLES+3)th clk rising edge after it. This covers 2 sync cycles, DEBOUNCE_CYCLES counting cycles, and 1 cycle for edge detect and output register.
- A button held through reset deassertion is treated as a new press once debounced.
- RUN: on run press, enable <= ~enable. This is independent of the load FSM.
- cdone edges: rise = cdone & ~cdone_q, where cdone_q is cdone registered on clk.
- Load FSM, 3 states:
  - IDLE: on load press, load <= synchronized sw_load, load_enable <= 1, go to ARMED. Any rise detected in IDLE is ignored.
  - ARMED: on rise, go to HOLD. A rise counts only if detected while in ARMED, which guarantees load_enable was high at least one clk before that cdone edge.
  - HOLD: on cdone == 0, load_enable <= 0 and go to IDLE.
- load_busy = (state != IDLE), registered alongside load_enable.
- Load presses in ARMED or HOLD are dropped. load keeps its captured value until the next accepted capture.
- cdone stuck low leaves the FSM in ARMED indefinitely. This is legal, and the bench must not flag it.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset 3 cycles with all raw inputs high, then release.
  - During reset and on the first cycle after: enable=0, load=0, load_enable=0, load_busy=0.
  - Raw inputs held high: RUN press registers at edge 7 after release, giving enable=1.
- Bounce: btn_run_raw toggles every 2 clk for 12 cycles, then held high.
  - enable rises exactly once, at the 7th edge after the last raw edge.
  - Holding high for 50 more cycles changes nothing.
  - A release followed by a 10-cycle press returns enable to 0.
- Glitch: btn_load_raw high for 3 cycles, then low → load_enable never asserts and load stays 0.
- Handshake: sw_load_raw=4'h9 with cdone=0, then press LOAD.
  - At press latency: load=9, load_enable=1, load_busy=1.
  - Both stay high for 20 cycles.
  - cdone goes high for 5 cycles, then low → load_enable and load_busy drop on the 2nd edge after cdone falls.
- Dropped press: in ARMED, set sw_load_raw=4'h5 and press LOAD.
  - load stays 9 through completion.
  - A later press in IDLE captures 5.
- Reset mid-operation: assert reset while in HOLD → the next edge shows load=0, load_enable=0, enable=0, and the FSM is IDLE.
